// File: rtl/partoserial.sv
// Parallel-to-serial transmitter: 8-bit words out MSB-first on clk_8f, comma fill when idle,
// with a post-reset comma burst so the far-end receiver can lock before data flows.
module partoserial #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned SYNC_COMMAS = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic [7:0] data_par,
  input  logic       valid_par,
  output logic       ready_par,
  output logic       out,
  output logic       active,
  output logic       comma_err
);

  typedef enum logic [0:0] {StSync, StActive} state_e;

  localparam logic [3:0] LastComma = 4'(SYNC_COMMAS - 1);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q;
  logic       hold_full_q, hold_full_d;
  logic       comma_err_q;
  logic       boundary;
  logic       accept;
  logic       unload;

  assign boundary = (bit_cnt_q == 3'd7);
  // ready_par depends only on the holding flop, so accept never races an unload
  assign accept   = valid_par && !hold_full_q;

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StSync && boundary && comma_cnt_q == LastComma) begin
      state_d = StActive;
    end
  end

  always_comb begin
    shift_d     = {shift_q[6:0], 1'b0};
    comma_cnt_d = comma_cnt_q;
    unload      = 1'b0;
    if (boundary) begin
      unique case (state_q)
        StSync: begin
          shift_d     = COMMA;
          comma_cnt_d = comma_cnt_q + 4'd1;
        end
        StActive: begin
          if (hold_full_q) begin
            shift_d = hold_q;
            unload  = 1'b1;
          end else begin
            shift_d = COMMA;
          end
        end
        default: shift_d = COMMA;
      endcase
    end
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_full_d = 1'b1;
    end else if (unload) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q   <= 3'd7;
      comma_cnt_q <= 4'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      comma_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_q + 3'd1;
      comma_cnt_q <= comma_cnt_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      comma_err_q <= accept && (data_par == COMMA);
      if (accept) begin
        hold_q <= data_par;
      end
    end
  end

  assign out       = shift_q[7];
  assign ready_par = !hold_full_q;
  assign active    = (state_q == StActive);
  assign comma_err = comma_err_q;

endmodule

// File: doc/partoserial.md
Name: partoserial

Overview:
Parallel-to-serial transmitter for the PHY link. It serialises 8-bit words MSB-first on a single bit-rate clock (clk_8f). Idle slots are filled with the comma/sync byte, and a configurable burst of commas is sent after reset so the far-end serialtopar receiver can lock. A one-entry holding buffer with a valid/ready handshake decouples the upstream word source from the byte-boundary timing.

Parameters:
COMMA, 8'hBC, sync/idle byte sent when no data is pending.
SYNC_COMMAS, 4, number of commas sent after reset before data may be sent (range 1..15).

Ports:
clk_8f  input  1  bit-rate clock, one serial bit per rising edge.
reset_L  input  1  asynchronous, active-low reset.
data_par  input  8  parallel word to transmit.
valid_par  input  1  data_par is valid this cycle.
ready_par  output  1  holding buffer empty; the word is accepted on an edge where valid_par && ready_par.
out  output  1  serial data, MSB first, registered.
active  output  1  sync burst complete; data words may now be serialised.
comma_err  output  1  one-cycle pulse when an accepted word equals COMMA.

Behaviour:
- Clock and reset: one clock, clk_8f. reset_L is asynchronous and active-low. All flops reset immediately on reset_L=0.
- Reset values:
  - shift_reg=0, so out=0.
  - bit_cnt=7; hold_full=0, so ready_par=1.
  - state=SYNC, comma_cnt=0, active=0, comma_err=0.
- Outputs:
  - out = shift_reg[7].
  - ready_par = !hold_full (pure decode of a flop, no combinational path from valid_par).
- Bit counter: bit_cnt (3 bits) increments every edge and wraps 7->0. An edge with bit_cnt==7 is a byte boundary.
  - On a boundary edge, shift_reg loads a new byte.
  - On every other edge, shift_reg <= {shift_reg[6:0],1'b0}.
- First boundary is the first edge after reset release, so the first byte's MSB appears on out after edge 1.
- FSM states:
  - SYNC: every boundary loads COMMA and comma_cnt increments. The boundary that loads the SYNC_COMMAS-th comma also sets state<=ACTIVE and active<=1 on that same edge.
  - ACTIVE: on a boundary, if hold_full, load the held word into shift_reg and clear hold_full; otherwise load COMMA (idle fill). ACTIVE is left only by reset.
- Holding buffer:
  - Accept occurs when valid_par && ready_par on an edge: hold<=data_par, hold_full<=1.
  - Words may be accepted during SYNC. They are held until the first ACTIVE boundary.
  - Because ready_par=0 while full, an accept and an unload can never hit the same edge. ready_par returns to 1 on the edge after the unload.
  - Maximum sustained throughput is one word per 8 clocks.
- Latency: a word held before a boundary in ACTIVE starts on out after that boundary edge. Bits follow on 8 consecutive edges, MSB first.
- First data slot: with SYNC_COMMAS=4, boundaries fall at edges 1, 9, 17 and 25 (commas). The earliest data boundary is edge 33.
- comma_err: pulses high for the one cycle after an accept whose data_par==COMMA. The word is still transmitted unchanged. The receiver treats it as control.
- Holding valid_par with ready_par=0: no effect, no data loss. The upstream source holds the word until it is accepted.
- Reset mid-byte: the partial byte is dropped and the held word is discarded. The full SYNC_COMMAS comma burst restarts after release.
- Arithmetic: comma_cnt is 4 bits and saturates once ACTIVE (no further increments). bit_cnt wraps modulo 8.

Test Plan:
- Sync burst: reset released, valid_par=0 -> out carries 1011_1100 repeated for 40 edges (4 sync commas plus 1 idle comma); active rises on edge 25.
- Early word: data_par=8'hA5 pulsed at edge 3 -> ready_par=0 from edge 4; out shows 1,0,1,0,0,1,0,1 after edges 33..40; ready_par=1 from edge 34.
- Back-to-back: valid_par held high with words 8'h01, 8'h02, 8'h03 in ACTIVE -> each serialised in consecutive 8-bit slots with no comma between them; each word is accepted on the edge after the previous unload.
- Idle gap: word 8'h3C, then valid_par low for 16 edges, then 8'hFF -> out shows 3C, BC, BC, FF byte-aligned.
- Comma as data: data_par=8'hBC accepted -> comma_err=1 for exactly one cycle; BC is sent in the next free slot.
- Reset mid-byte: assert reset_L=0 at bit 4 of a data byte with hold_full=1 -> out=0 and ready_par=1 immediately; after release, 4 commas are sent before any data and the held word is not transmitted.
